// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word load or store request at a time,
// drives a word-aligned single-port memory with a registered read port, and
// returns a one-cycle completion pulse with the extended load result.
// Sub-word stores at a non-zero offset use a read-modify-write through MERGE.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_addr/req_wen/req_funct3    byte address, 1=store, RISC-V size code
//   req_wdata                      store data in its low bytes
//   resp_valid/resp_rdata/resp_err completion pulse, load result, error flag
//   d_addr/wen/wty/wdata           memory address (word aligned), write controls
//   rdata                          memory read word, valid the cycle after d_addr
module load_store_unit #(
    parameter int unsigned WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] rdata,
    output logic                wen,
    output logic [1:0]          wty,
    output logic [WORD_LEN-1:0] wdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_MERGE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state_q,  state_d;
    logic [WORD_LEN-1:0] addr_q,   addr_d;
    logic                store_q,  store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [WORD_LEN-1:0] wdata_q,  wdata_d;
    logic                err_q,    err_d;

    logic                req_err_c;
    logic                rmw_c;
    logic [4:0]          byte_sh_c;
    logic [4:0]          half_sh_c;
    logic [WORD_LEN-1:0] byte_word_c;
    logic [WORD_LEN-1:0] half_word_c;
    logic [WORD_LEN-1:0] load_ext_c;
    logic [WORD_LEN-1:0] lane_mask_c;
    logic [WORD_LEN-1:0] merge_c;
    logic [WORD_LEN-1:0] word_addr_c;

    // Classify the presented request: illegal size code or misaligned access.
    always_comb begin
        req_err_c = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 ||
            (req_funct3[2] && req_wen)) begin
            req_err_c = 1'b1;
        end else if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_err_c = 1'b1;
        end else if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_err_c = 1'b1;
        end
    end

    // Legal stores off lane 0 can only be SB at 1..3 or SH at 2: read first, then merge.
    assign rmw_c       = store_q && (addr_q[1:0] != 2'b00);
    assign word_addr_c = {addr_q[WORD_LEN-1:2], 2'b00};

    // Lane extraction for loads and lane replacement for read-modify-write stores.
    always_comb begin
        byte_sh_c   = {addr_q[1:0], 3'b000};
        half_sh_c   = {addr_q[1], 4'b0000};
        byte_word_c = rdata >> byte_sh_c;
        half_word_c = rdata >> half_sh_c;
        case (funct3_q)
            3'b000:  load_ext_c = {{(WORD_LEN-8){byte_word_c[7]}}, byte_word_c[7:0]};
            3'b001:  load_ext_c = {{(WORD_LEN-16){half_word_c[15]}}, half_word_c[15:0]};
            3'b010:  load_ext_c = rdata;
            3'b100:  load_ext_c = {{(WORD_LEN-8){1'b0}}, byte_word_c[7:0]};
            3'b101:  load_ext_c = {{(WORD_LEN-16){1'b0}}, half_word_c[15:0]};
            default: load_ext_c = '0;
        endcase
        lane_mask_c = funct3_q[0] ? WORD_LEN'(16'hFFFF) : WORD_LEN'(8'hFF);
        merge_c     = (rdata & ~(lane_mask_c << byte_sh_c)) |
                      ((wdata_q & lane_mask_c) << byte_sh_c);
    end

    // Next-state and request capture.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    store_d  = req_wen;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    err_d    = req_err_c;
                    state_d  = req_err_c ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = rmw_c ? S_MERGE : S_RESP;
            S_MERGE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state; reset forces IDLE so every output is quiet at once.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        d_addr     = '0;
        wen        = 1'b0;
        wty        = 2'b00;
        wdata      = '0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE: begin
                d_addr = word_addr_c;
                if (store_q && !rmw_c) begin
                    wen   = 1'b1;
                    wty   = funct3_q[1:0];
                    wdata = wdata_q;
                end
            end
            S_MERGE: begin
                d_addr = word_addr_c;
                wen    = 1'b1;
                wty    = 2'b10;
                wdata  = merge_c;
            end
            default: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !store_q) begin
                    resp_rdata = load_ext_c;
                end
            end
        endcase
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: LoadStoreUnit

Interface
REQ-001 The parameter WORD_LEN SHALL default to 32 and SHALL set the width of all data and address ports.
REQ-002 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-low reset.
REQ-004 Port req_valid SHALL be an input, 1 bit wide, signalling that a request is presented.
REQ-005 Port req_ready SHALL be an output, 1 bit wide, signalling that the unit can accept a request.
REQ-006 Port req_addr SHALL be an input, WORD_LEN bits wide, carrying the byte address.
REQ-007 Port req_wen SHALL be an input, 1 bit wide, selecting 1=store, 0=load.
REQ-008 Port req_funct3 SHALL be an input, 3 bits wide, encoding loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU and stores 000 SB, 001 SH, 010 SW.
REQ-009 Port req_wdata SHALL be an input, WORD_LEN bits wide, carrying store data in its low bytes.
REQ-010 Port resp_valid SHALL be an output, 1 bit wide, as a one-cycle completion pulse.
REQ-011 Port resp_rdata SHALL be an output, WORD_LEN bits wide, carrying the extended load result.
REQ-012 Port resp_err SHALL be an output, 1 bit wide, flagging a misaligned or illegal request; it is valid only with resp_valid.
REQ-013 Port d_addr SHALL be an output, WORD_LEN bits wide, driving the word-aligned memory address (bits [1:0]=0).
REQ-014 Port rdata SHALL be an input, WORD_LEN bits wide, carrying the memory read word: registered, valid the cycle after d_addr is driven, little-endian (byte0 = [7:0]).
REQ-015 Port wen SHALL be an output, 1 bit wide, as the memory write enable.
REQ-016 Port wty SHALL be an output, 2 bits wide, giving the write size: 0 = byte at offset 0, 1 = half at offset 0, 2 = full word.
REQ-017 Port wdata SHALL be an output, WORD_LEN bits wide, carrying the memory write word in little-endian order.

Function
REQ-018 The state machine SHALL have the states IDLE, ISSUE, MERGE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready, with addr, wen, funct3 and wdata latched at acceptance.
REQ-020 A request SHALL be classified at acceptance as follows:
- illegal funct3 (011, 11x; or 10x with a store) -> error;
- LH/LHU/SH with addr[0]=1 -> error;
- LW/SW with addr[1:0]!=0 -> error;
- any other request -> legal.
REQ-021 On an error request, IDLE SHALL go to RESP, and in the next cycle resp_valid=1, resp_err=1, resp_rdata=0, with no memory access.
REQ-022 On a legal request, IDLE SHALL go to ISSUE, with d_addr = {addr[WORD_LEN-1:2],2'b00} held through ISSUE and MERGE.
REQ-023 For a load in ISSUE: wen=0; next state RESP; in RESP resp_rdata SHALL be extracted from rdata:
- byte = rdata >> (8*addr[1:0]);
- half = rdata >> (16*addr[1]);
- LB/LH sign-extended, LBU/LHU zero-extended, LW unmodified.
REQ-024 For an aligned-offset store (SB/SH at offset 0, or SW) in ISSUE: wen=1, wty=0/1/2 per size, wdata=req_wdata; next state RESP.
REQ-025 For SB at offset 1..3 or SH at offset 2 in ISSUE: wen=0 (read), then go to MERGE.
REQ-026 In MERGE: wen=1, wty=2, wdata = rdata with the target byte/half lanes replaced by req_wdata low bits; next state RESP.
REQ-027 In RESP: resp_valid=1 for exactly one cycle, then IDLE; for stores resp_rdata=0 and resp_err=0.
REQ-028 Latency from accept SHALL be: error 1 cycle, load 2, direct store 2, read-modify-write store 3.
REQ-029 Outside ISSUE and MERGE: wen=0, and d_addr, wty and wdata SHALL be 0.
REQ-030 wen SHALL never be 1 in two consecutive cycles for the same request, except in the ISSUE-read followed by MERGE-write sequence (read then write).
REQ-031 Address arithmetic SHALL ignore overflow; d_addr passes the upper address bits unmodified.

Reset
REQ-032 When rst_n=0, the unit SHALL asynchronously force state=IDLE, req_ready=1 and resp_valid=resp_err=0, with resp_rdata, d_addr, wty and wdata all 0 and wen=0.
REQ-033 Reset asserted mid-operation SHALL abort the request without a response; no memory write SHALL occur after reset is asserted.
REQ-034 After rst_n rises, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-035 The bench SHALL cover the following directed scenarios; memory word 0x100 = 0x8899AABB before each.
- LB @0x101: accept -> d_addr=0x100, wen=0 the next cycle -> resp_rdata=0xFFFFFFAA 2 cycles after accept; LBU -> 0x000000AA.
- LH @0x102 -> 0xFFFF8899; LHU @0x102 -> 0x00008899; LW @0x100 -> 0x8899AABB.
- SB @0x102, wdata=0x12345677 -> ISSUE wen=0; MERGE wen=1, wty=2, wdata=0x8877AABB; resp_valid 3 cycles after accept; a following LW @0x100 -> 0x8877AABB.
- SH @0x100, wdata=0xCAFE1234 -> ISSUE wen=1, wty=1, wdata=0xCAFE1234; a following LW @0x100 -> 0x88991234.
- LW @0x102, SH @0x101, and funct3=011 -> resp_valid=1, resp_err=1 one cycle after accept; wen never asserted.
- SB @0x103 with rst_n pulsed low during ISSUE -> wen stays 0, memory unchanged, no resp_valid, req_ready=1 after release.
